exp_golomb_pipe_decoder: RTL and testbench

EXP_GOLOMB_PIPE_DECODER -- requirements
Module: exp_golomb_pipe_decoder

---
 rtl/exp_golomb_pkg.sv | 21 ++
 rtl/exp_golomb_pipe_decoder_lzc.sv | 29 ++
 rtl/exp_golomb_pipe_decoder.sv | 144 ++++++++++++++
 tb/tb_exp_golomb_pipe_decoder.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_golomb_pkg.sv
// Shared definitions for the Exp-Golomb pipeline decoder: mode encodings
// and the window-derived size helpers.
package exp_golomb_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_UE   = 2'b01,
        MODE_SE   = 2'b10,
        MODE_TE   = 2'b11
    } eg_mode_e;

    // Largest prefix whose full 2*lz+1 code still fits in the window.
    function automatic int eg_lz_max(input int win_w);
        return (win_w - 1) / 2;
    endfunction

    function automatic int eg_len_w(input int win_w);
        return $clog2(win_w + 1);
    endfunction

endpackage

// File: rtl/exp_golomb_pipe_decoder_lzc.sv
// Combinational leading-zero counter over the bitstream window (MSB first).
// lz saturates at WIN_W for an all-zero window.
module eg_lzc
    import exp_golomb_pkg::*;
#(
    parameter int WIN_W = 32
) (
    input  logic [WIN_W-1:0]           win,
    output logic [eg_len_w(WIN_W)-1:0] lz,
    output logic                       all_zero
);

    localparam int LZ_W = eg_len_w(WIN_W);

    logic found;

    always_comb begin
        lz    = LZ_W'(WIN_W);
        found = 1'b0;
        for (int i = WIN_W - 1; i >= 0; i--) begin
            if (win[i] && !found) begin
                lz    = LZ_W'(WIN_W - 1 - i);
                found = 1'b1;
            end
        end
        all_zero = !found;
    end

endmodule

// File: rtl/exp_golomb_pipe_decoder.sv
// Two-stage Exp-Golomb decoder (ue/se/te): S1 captures the prefix length,
// S2 holds the decoded result until the consumer takes it.
module exp_golomb_pipe_decoder
    import exp_golomb_pkg::*;
#(
    parameter int WIN_W = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIN_W-1:0]           bits_window,
    input  logic [1:0]                 mode,
    input  logic                       te_cmax_one,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_value,
    output logic [eg_len_w(WIN_W)-1:0] out_len,
    output logic                       out_err,
    output logic                       err_sticky,
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           sym_count
);

    localparam int LEN_W  = eg_len_w(WIN_W);
    localparam int LZ_MAX = eg_lz_max(WIN_W);

    logic [LEN_W-1:0] lz_in;
    logic             all_zero_in;

    eg_lzc #(.WIN_W(WIN_W)) u_lzc (
        .win      (bits_window),
        .lz       (lz_in),
        .all_zero (all_zero_in)
    );

    logic             s1_valid;
    logic [LEN_W-1:0] s1_lz;
    logic [WIN_W-1:0] s1_win;
    eg_mode_e         s1_mode;
    logic             s1_cmax_one;
    logic             s1_all_zero;

    logic accept;
    logic s1_adv;
    logic deliver;

    assign deliver  = out_valid & out_ready;
    assign s1_adv   = s1_valid & (!out_valid | out_ready);
    assign in_ready = reset_n & (!s1_valid | s1_adv);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_lz       <= '0;
            s1_win      <= '0;
            s1_mode     <= MODE_NONE;
            s1_cmax_one <= 1'b0;
            s1_all_zero <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_lz       <= lz_in;
            s1_win      <= bits_window;
            s1_mode     <= eg_mode_e'(mode);
            s1_cmax_one <= te_cmax_one;
            s1_all_zero <= all_zero_in;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    logic             lz_over;
    logic [OUT_W-1:0] code_num;
    logic [OUT_W-1:0] dec_value;
    logic [LEN_W-1:0] dec_len;
    logic             dec_err;

    assign lz_over = s1_all_zero | (int'(s1_lz) > LZ_MAX);

    // The prefix zeros sit above the code field, so a right shift alone
    // isolates the lz+1 info bits; the shift is only legal once lz fits.
    always_comb begin
        code_num  = '0;
        dec_value = '0;
        dec_len   = '0;
        dec_err   = 1'b0;
        if (!lz_over) begin
            code_num = OUT_W'(s1_win >> (WIN_W - 1 - 2 * int'(s1_lz))) - OUT_W'(1);
        end
        if (s1_mode == MODE_NONE) begin
            dec_err = 1'b1;
        end else if (s1_mode == MODE_TE && s1_cmax_one) begin
            dec_value = OUT_W'(!s1_win[WIN_W-1]);
            dec_len   = LEN_W'(1);
        end else if (lz_over) begin
            dec_err = 1'b1;
        end else begin
            dec_len = LEN_W'(2 * int'(s1_lz) + 1);
            if (s1_mode == MODE_SE) begin
                dec_value = code_num[0] ? ((code_num + OUT_W'(1)) >> 1)
                                        : (OUT_W'(0) - (code_num >> 1));
            end else begin
                dec_value = code_num;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_len   <= '0;
            out_err   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_value <= dec_value;
            out_len   <= dec_len;
            out_err   <= dec_err;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // A new error wins over a same-cycle clear so no error is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
            sym_count  <= '0;
        end else begin
            if (deliver && out_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (deliver && !out_err) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exp_golomb_pipe_decoder.sv
// Self-checking bench: directed literal cases plus randomized traffic scored
// against a queue-based behavioural decoder model.
module tb_exp_golomb_pipe_decoder;

    localparam int WIN_W  = 32;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 16;
    localparam int LEN_W  = $clog2(WIN_W + 1);
    localparam int LZ_MAX = (WIN_W - 1) / 2;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] bits_window;
    logic [1:0]       mode;
    logic             te_cmax_one;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic [LEN_W-1:0] out_len;
    logic             out_err;
    logic             err_sticky;
    logic             err_clr;
    logic [CNT_W-1:0] sym_count;

    exp_golomb_pipe_decoder #(.WIN_W(WIN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bits_window (bits_window),
        .mode        (mode),
        .te_cmax_one (te_cmax_one),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_len     (out_len),
        .out_err     (out_err),
        .err_sticky  (err_sticky),
        .err_clr     (err_clr),
        .sym_count   (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [OUT_W-1:0] value;
        logic [LEN_W-1:0] len;
        logic             err;
    } res_t;

    // Decode straight from the code definition: count zeros, read the
    // info bits one by one, then map per mode.
    function automatic res_t model(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic c1);
        res_t   r;
        int     lz;
        longint num;
        r.value = '0;
        r.len   = '0;
        r.err   = 1'b0;
        lz = 0;
        while (lz < WIN_W && w[WIN_W-1-lz] == 1'b0) lz++;
        if (m == 2'b00) begin
            r.err = 1'b1;
            return r;
        end
        if (m == 2'b11 && c1) begin
            r.value = w[WIN_W-1] ? OUT_W'(0) : OUT_W'(1);
            r.len   = LEN_W'(1);
            return r;
        end
        if (lz > LZ_MAX) begin
            r.err = 1'b1;
            return r;
        end
        num = 0;
        for (int k = 0; k <= lz; k++) num = num * 2 + longint'(w[WIN_W-1-lz-k]);
        num = num - 1;
        r.len = LEN_W'(2 * lz + 1);
        if (m == 2'b10) begin
            if (num % 2 == 1) r.value = OUT_W'((num + 1) / 2);
            else              r.value = OUT_W'((longint'(1) << OUT_W) - num / 2);
        end else begin
            r.value = OUT_W'(num);
        end
        return r;
    endfunction

    function automatic logic [WIN_W-1:0] gen_win(input int lz);
        logic [63:0]      r;
        logic [WIN_W-1:0] w;
        r = {$urandom, $urandom};
        w = r[WIN_W-1:0];
        if (lz >= WIN_W) return '0;
        for (int i = 0; i < lz; i++) w[WIN_W-1-i] = 1'b0;
        w[WIN_W-1-lz] = 1'b1;
        return w;
    endfunction

    // Scoreboard: expected results queued at accept, checked at deliver.
    res_t             exp_q[$];
    int unsigned      m_cnt = 0;
    logic             m_sticky = 1'b0;
    logic             hold_prev = 1'b0;
    logic [OUT_W-1:0] hold_value;
    logic [LEN_W-1:0] hold_len;
    logic             hold_err;
    res_t             e;
    logic             del_err;

    always @(negedge clk) begin
        check("sym_count", 64'(sym_count), 64'(CNT_W'(m_cnt)));
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_value", 64'(out_value), 64'(hold_value));
            check("hold_len", 64'(out_len), 64'(hold_len));
            check("hold_err", 64'(out_err), 64'(hold_err));
        end
        if (!reset_n) begin
            check("in_ready_in_reset", 64'(in_ready), 64'(0));
            exp_q.delete();
            m_cnt     = 0;
            m_sticky  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            del_err = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_value", 64'(out_value), 64'(e.value));
                    check("out_len", 64'(out_len), 64'(e.len));
                    check("out_err", 64'(out_err), 64'(e.err));
                    del_err = e.err;
                    if (!e.err) m_cnt++;
                end
            end
            if (del_err) m_sticky = 1'b1;
            else if (err_clr) m_sticky = 1'b0;
            if (in_valid && in_ready) exp_q.push_back(model(bits_window, mode, te_cmax_one));
            hold_prev  = out_valid && !out_ready;
            hold_value = out_value;
            hold_len   = out_len;
            hold_err   = out_err;
        end
    end

    int stall_cnt = 0;

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    // with in_valid still high so back-to-back calls leave no gap.
    task automatic send(input logic [WIN_W-1:0] w, input logic [1:0] m, input logic c1);
        int tries;
        in_valid    = 1'b1;
        bits_window = w;
        mode        = m;
        te_cmax_one = c1;
        tries = 0;
        @(negedge clk);
        while (!in_ready && tries < 500) begin
            tries++;
            @(negedge clk);
        end
        stall_cnt += tries;
        if (tries >= 500) check("send_timeout", 64'(tries), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic send_and_expect(input string name, input logic [WIN_W-1:0] w, input logic [1:0] m,
                                   input logic c1, input logic [OUT_W-1:0] ev, input logic [LEN_W-1:0] el,
                                   input logic ee, input logic clr_on_deliver);
        out_ready = 1'b1;
        send(w, m, c1);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1_valid"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        err_clr = clr_on_deliver;
        @(negedge clk);
        check({name, "_lat2_valid"}, 64'(out_valid), 64'(1));
        check({name, "_value"}, 64'(out_value), 64'(ev));
        check({name, "_len"}, 64'(out_len), 64'(el));
        check({name, "_err"}, 64'(out_err), 64'(ee));
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    res_t        r;
    logic        prod_done;
    logic        tog;
    int          cyc;
    int          bad_valid;
    logic [1:0]  rm;
    logic        rc;
    logic [WIN_W-1:0] rw;

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        bits_window = '0;
        mode        = 2'b00;
        te_cmax_one = 1'b0;
        out_ready   = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_value", 64'(out_value), 64'(0));
        check("rst_sym_count", 64'(sym_count), 64'(0));
        @(posedge clk); #1;

        r = model(32'h3FFF_FFFF, 2'b01, 1'b0);
        check("model_ue_value", 64'(r.value), 64'd6);
        check("model_ue_len", 64'(r.len), 64'd5);
        r = model(32'h2800_0000, 2'b10, 1'b0);
        check("model_se_neg", 64'(r.value), 64'hFFFE);
        r = model(32'h4000_0000, 2'b11, 1'b0);
        check("model_te_len", 64'(r.len), 64'd3);
        r = model(32'h0000_0000, 2'b01, 1'b0);
        check("model_zero_err", 64'(r.err), 64'd1);

        send_and_expect("ue_6", 32'h3FFF_FFFF, 2'b01, 1'b0, 16'd6, 6'd5, 1'b0, 1'b0);
        send_and_expect("se_pos2", 32'h2000_0000, 2'b10, 1'b0, 16'd2, 6'd5, 1'b0, 1'b0);
        send_and_expect("se_neg2", 32'h2800_0000, 2'b10, 1'b0, 16'hFFFE, 6'd5, 1'b0, 1'b0);
        send_and_expect("te_c1", 32'h7FFF_FFFF, 2'b11, 1'b1, 16'd1, 6'd1, 1'b0, 1'b0);
        send_and_expect("te_c0", 32'h4000_0000, 2'b11, 1'b0, 16'd1, 6'd3, 1'b0, 1'b0);

        send_and_expect("zero_ue", 32'h0, 2'b01, 1'b0, 16'd0, 6'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("zero_sticky", 64'(err_sticky), 64'(1));
        check("zero_count_unchanged", 64'(sym_count), 64'd5);
        @(posedge clk); #1;
        send_and_expect("none_mode", 32'h8000_0000, 2'b00, 1'b0, 16'd0, 6'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("set_beats_clear", 64'(err_sticky), 64'(1));
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 64'(err_sticky), 64'(0));
        @(posedge clk); #1;

        // Two symbols in flight, then reset.
        out_ready = 1'b0;
        send(gen_win(3), 2'b01, 1'b0);
        send(gen_win(1), 2'b10, 1'b0);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        check("post_rst_out_valid", 64'(out_valid), 64'(0));
        check("post_rst_out_value", 64'(out_value), 64'(0));
        check("post_rst_out_len", 64'(out_len), 64'(0));
        check("post_rst_out_err", 64'(out_err), 64'(0));
        check("post_rst_sym_count", 64'(sym_count), 64'(0));
        bad_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) bad_valid++;
        end
        check("post_rst_no_valid", 64'(bad_valid), 64'(0));
        @(posedge clk); #1;

        // Back-to-back stream with out_ready toggling 1010...
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(gen_win($urandom_range(0, LZ_MAX)), 2'b01, 1'b0);
                in_valid  = 1'b0;
                prod_done = 1'b1;
            end
            begin
                tog = 1'b1;
                cyc = 0;
                while (!(prod_done && exp_q.size() == 0 && !out_valid) && cyc < 200) begin
                    out_ready = tog;
                    tog = !tog;
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        join
        check("toggle_drain_timeout", 64'(cyc < 200), 64'(1));
        @(negedge clk);
        check("toggle_sym_count", 64'(sym_count), 64'd8);
        @(posedge clk); #1;

        // Full throughput: no stalls with the consumer always ready.
        out_ready = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(gen_win($urandom_range(0, LZ_MAX)), 2'b10, 1'b0);
        in_valid = 1'b0;
        check("full_rate_stalls", 64'(stall_cnt), 64'(0));
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("full_rate_sym_count", 64'(sym_count), 64'd16);
        @(posedge clk); #1;

        // Randomized traffic.
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    rm = 2'($urandom_range(0, 3));
                    rc = 1'($urandom_range(0, 1));
                    rw = ($urandom_range(0, 19) == 0) ? '0 : gen_win($urandom_range(0, LZ_MAX + 2));
                    if (rm == 2'b11 && rc && rw == '0) rw = 1;
                    send(rw, rm, rc);
                    if ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    end
                end
                in_valid  = 1'b0;
                prod_done = 1'b1;
            end
            begin
                cyc = 0;
                while (!prod_done && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    err_clr   = ($urandom_range(0, 19) == 0);
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b1;
                err_clr   = 1'b0;
            end
        join
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        check("random_drained", 64'(exp_q.size()), 64'(0));
        check("random_out_valid_idle", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
